// File: rtl/panda_pkg.sv
// Shared Panda types: LSU access widths, LSU FSM states and the captured request.
package panda_pkg;

   typedef enum logic [1:0] {
      LSU_BYTE = 2'd0,
      LSU_HALF = 2'd1,
      LSU_WORD = 2'd2
   } lsu_width_e;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      REQ1  = 3'd1,
      RESP1 = 3'd2,
      REQ2  = 3'd3,
      RESP2 = 3'd4,
      ERR   = 3'd5
   } lsu_state_e;

   typedef struct packed {
      logic       store;
      logic       load_unsigned;
      lsu_width_e width;
      logic [31:0] addr;
      logic [31:0] wdata;
   } lsu_req_t;

   // Unshifted byte-enable pattern for an access width.
   function automatic logic [3:0] lsu_width_mask(input lsu_width_e w);
      case (w)
         LSU_BYTE: return 4'b0001;
         LSU_HALF: return 4'b0011;
         default:  return 4'b1111;
      endcase
   endfunction

endpackage

// File: rtl/panda_lsu_align.sv
// Combinational lane steering: two-beat byte enables / write data, word-crossing
// flag, and load extraction from a pair of read beats.
module panda_lsu_align
   import panda_pkg::*;
(
   input  logic [1:0]  i_off,
   input  lsu_width_e  i_width,
   input  logic        i_unsigned,
   input  logic [31:0] i_store_data,
   input  logic [31:0] i_rdata_lo,
   input  logic [31:0] i_rdata_hi,
   output logic [7:0]  o_be8,
   output logic [63:0] o_wd64,
   output logic        o_cross,
   output logic [31:0] o_load
);

   logic [63:0] w_rd64;

   assign o_be8   = {4'b0000, lsu_width_mask(i_width)} << i_off;
   assign o_wd64  = {32'h0000_0000, i_store_data} << {i_off, 3'b000};
   assign o_cross = |o_be8[7:4];
   assign w_rd64  = {i_rdata_hi, i_rdata_lo} >> {i_off, 3'b000};

   always_comb begin
      o_load = w_rd64[31:0];
      case (i_width)
         LSU_BYTE: o_load = {{24{~i_unsigned & w_rd64[7]}},  w_rd64[7:0]};
         LSU_HALF: o_load = {{16{~i_unsigned & w_rd64[15]}}, w_rd64[15:0]};
         default:  o_load = w_rd64[31:0];
      endcase
   end

endmodule

// File: rtl/panda_lsu_obi.sv
// Multi-cycle load/store unit on a request/grant/response data bus; one access
// in flight, word-crossing accesses optionally split into two beats.
module panda_lsu_obi
   import panda_pkg::*;
#(
   parameter int MISALIGNED_SPLIT = 1
)(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req_i,
   input  logic        store_i,
   input  logic        load_unsigned_i,
   input  lsu_width_e  width_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] store_data_i,
   output logic        busy_o,
   output logic        valid_o,
   output logic        err_o,
   output logic [31:0] load_data_o,
   output logic        data_req_o,
   input  logic        data_gnt_i,
   output logic [31:0] data_addr_o,
   output logic        data_we_o,
   output logic [3:0]  data_be_o,
   output logic [31:0] data_wdata_o,
   input  logic        data_rvalid_i,
   input  logic [31:0] data_rdata_i,
   input  logic        data_err_i
);

   lsu_state_e  r_state, w_next;
   lsu_req_t    r_req, w_cur;
   logic [31:0] r_rdata1;
   logic        r_valid, r_err;
   logic [31:0] r_load_data;
   logic [31:0] r_addr, r_wdata;
   logic        r_we;
   logic [3:0]  r_be;

   logic        w_cap, w_beat1, w_beat2, w_done, w_fail;
   logic [7:0]  w_be8;
   logic [63:0] w_wd64;
   logic        w_cross;
   logic [31:0] w_load, w_rlo, w_rhi;

   // In IDLE the aligner looks at the live request so beat 1 can be launched
   // straight from the capture cycle; afterwards it works on the latched copy.
   always_comb begin
      w_cur = r_req;
      if (r_state == IDLE) begin
         w_cur.store         = store_i;
         w_cur.load_unsigned = load_unsigned_i;
         w_cur.width         = width_i;
         w_cur.addr          = addr_i;
         w_cur.wdata         = store_data_i;
      end
   end

   assign w_rlo = (r_state == RESP2) ? r_rdata1     : data_rdata_i;
   assign w_rhi = (r_state == RESP2) ? data_rdata_i : 32'h0000_0000;

   panda_lsu_align u_align (
      .i_off        (w_cur.addr[1:0]),
      .i_width      (w_cur.width),
      .i_unsigned   (w_cur.load_unsigned),
      .i_store_data (w_cur.wdata),
      .i_rdata_lo   (w_rlo),
      .i_rdata_hi   (w_rhi),
      .o_be8        (w_be8),
      .o_wd64       (w_wd64),
      .o_cross      (w_cross),
      .o_load       (w_load)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) r_state <= IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next  = r_state;
      w_cap   = 1'b0;
      w_beat1 = 1'b0;
      w_beat2 = 1'b0;
      w_done  = 1'b0;
      w_fail  = 1'b0;
      case (r_state)
         IDLE: begin
            if (req_i) begin
               w_cap = 1'b1;
               if (w_cross && (MISALIGNED_SPLIT == 0)) begin
                  w_next = ERR;
               end else begin
                  w_next  = REQ1;
                  w_beat1 = 1'b1;
               end
            end
         end
         REQ1:  if (data_gnt_i) w_next = RESP1;
         RESP1: begin
            if (data_rvalid_i) begin
               if (data_err_i) begin
                  w_next = IDLE;
                  w_done = 1'b1;
                  w_fail = 1'b1;
               end else if (w_cross) begin
                  w_next  = REQ2;
                  w_beat2 = 1'b1;
               end else begin
                  w_next = IDLE;
                  w_done = 1'b1;
               end
            end
         end
         REQ2:  if (data_gnt_i) w_next = RESP2;
         RESP2: begin
            if (data_rvalid_i) begin
               w_next = IDLE;
               w_done = 1'b1;
               w_fail = data_err_i;
            end
         end
         ERR: begin
            w_next = IDLE;
            w_done = 1'b1;
            w_fail = 1'b1;
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_req       <= '0;
         r_rdata1    <= 32'h0000_0000;
         r_valid     <= 1'b0;
         r_err       <= 1'b0;
         r_load_data <= 32'h0000_0000;
         r_addr      <= 32'h0000_0000;
         r_we        <= 1'b0;
         r_be        <= 4'b0000;
         r_wdata     <= 32'h0000_0000;
      end else begin
         r_valid <= w_done;
         r_err   <= w_done & w_fail;
         if (w_cap) r_req <= w_cur;
         // Bus fields only move on beat launch, so they hold through grant stalls.
         if (w_beat1) begin
            r_addr  <= {w_cur.addr[31:2], 2'b00};
            r_we    <= w_cur.store;
            r_be    <= w_be8[3:0];
            r_wdata <= w_wd64[31:0];
         end
         if (w_beat2) begin
            r_addr  <= r_addr + 32'd4;
            r_be    <= w_be8[7:4];
            r_wdata <= w_wd64[63:32];
         end
         if ((r_state == RESP1) && data_rvalid_i) r_rdata1 <= data_rdata_i;
         if (w_done && !w_fail && !r_req.store) r_load_data <= w_load;
      end
   end

   assign busy_o       = (r_state != IDLE);
   assign valid_o      = r_valid;
   assign err_o        = r_err;
   assign load_data_o  = r_load_data;
   assign data_req_o   = (r_state == REQ1) || (r_state == REQ2);
   assign data_addr_o  = r_addr;
   assign data_we_o    = r_we;
   assign data_be_o    = r_be;
   assign data_wdata_o = r_wdata;

endmodule

// File: tb/tb_panda_lsu_obi.sv
// Scoreboard bench: stimulus queues expected bus beats and completions; a bus
// responder and a completion monitor check them independently.
module tb_panda_lsu_obi;
   import panda_pkg::*;

   typedef struct {
      logic [31:0] addr;
      logic        we;
      logic [3:0]  be;
      logic [31:0] wdata;
      bit          chk_wd;
      int          stall;
      logic [31:0] rdata;
      logic        err;
   } beat_t;

   typedef struct {
      logic        err;
      bit          chk;
      logic [31:0] data;
      int          lat;
      int          issue;
   } exp_t;

   logic clk, rst, req0, req1, store, uns;
   lsu_width_e width;
   logic [31:0] addr, sdata;
   logic gnt, rvalid, derr;
   logic [31:0] rdata;

   logic busy0, valid0, err0, dreq0, dwe0;
   logic [31:0] ld0, daddr0, dwd0;
   logic [3:0] dbe0;
   logic busy1, valid1, err1, dreq1, dwe1;
   logic [31:0] ld1, daddr1, dwd1;
   logic [3:0] dbe1;

   beat_t beat_q[$];
   exp_t  exp0_q[$];
   exp_t  exp1_q[$];
   int    n_chk = 0;
   int    n_err = 0;
   int    cyc = 0;

   panda_lsu_obi #(.MISALIGNED_SPLIT(1)) dut0 (
      .clk_i(clk), .rst_i(rst), .req_i(req0), .store_i(store), .load_unsigned_i(uns),
      .width_i(width), .addr_i(addr), .store_data_i(sdata),
      .busy_o(busy0), .valid_o(valid0), .err_o(err0), .load_data_o(ld0),
      .data_req_o(dreq0), .data_gnt_i(gnt), .data_addr_o(daddr0), .data_we_o(dwe0),
      .data_be_o(dbe0), .data_wdata_o(dwd0), .data_rvalid_i(rvalid),
      .data_rdata_i(rdata), .data_err_i(derr));

   panda_lsu_obi #(.MISALIGNED_SPLIT(0)) dut1 (
      .clk_i(clk), .rst_i(rst), .req_i(req1), .store_i(store), .load_unsigned_i(uns),
      .width_i(width), .addr_i(addr), .store_data_i(sdata),
      .busy_o(busy1), .valid_o(valid1), .err_o(err1), .load_data_o(ld1),
      .data_req_o(dreq1), .data_gnt_i(gnt), .data_addr_o(daddr1), .data_we_o(dwe1),
      .data_be_o(dbe1), .data_wdata_o(dwd1), .data_rvalid_i(rvalid),
      .data_rdata_i(rdata), .data_err_i(derr));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not reach its end");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
      n_chk++;
      if (act !== want) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, want);
      end
   endtask

   // Bus slave: grants after the beat's stall count, responds one cycle later,
   // and checks the request fields on every cycle the request is up.
   initial begin : responder
      int    stall_cnt;
      bit    pending;
      beat_t cur;
      stall_cnt = 0;
      pending = 1'b0;
      gnt = 1'b0; rvalid = 1'b0; rdata = 32'h0; derr = 1'b0;
      forever begin
         @(negedge clk);
         gnt = 1'b0; rvalid = 1'b0; rdata = 32'h0; derr = 1'b0;
         if (pending) begin
            rvalid  = 1'b1;
            rdata   = cur.rdata;
            derr    = cur.err;
            pending = 1'b0;
         end else if (dreq0 && !rst) begin
            if (beat_q.size() == 0) begin
               n_chk++; n_err++;
               $display("FAIL bus_unexpected_req: addr %h be %b", daddr0, dbe0);
            end else begin
               cur = beat_q[0];
               check("bus_addr", daddr0, cur.addr);
               check("bus_we", {31'b0, dwe0}, {31'b0, cur.we});
               check("bus_be", {28'b0, dbe0}, {28'b0, cur.be});
               if (cur.chk_wd) check("bus_wdata", dwd0, cur.wdata);
               if (stall_cnt < cur.stall) begin
                  stall_cnt++;
               end else begin
                  gnt = 1'b1;
                  stall_cnt = 0;
                  pending = 1'b1;
                  void'(beat_q.pop_front());
               end
            end
         end
      end
   end

   // Completion monitor.
   always @(negedge clk) begin : monitor
      exp_t e;
      if (!rst) begin
         if (valid0) begin
            if (exp0_q.size() == 0) begin
               n_chk++; n_err++;
               $display("FAIL dut0_unexpected_valid: got valid_o=1, expected 0");
            end else begin
               e = exp0_q.pop_front();
               check("dut0_err", {31'b0, err0}, {31'b0, e.err});
               if (e.chk) check("dut0_load_data", ld0, e.data);
               check("dut0_latency", cyc - e.issue, e.lat);
            end
         end
         if (valid1) begin
            if (exp1_q.size() == 0) begin
               n_chk++; n_err++;
               $display("FAIL dut1_unexpected_valid: got valid_o=1, expected 0");
            end else begin
               e = exp1_q.pop_front();
               check("dut1_err", {31'b0, err1}, {31'b0, e.err});
               if (e.chk) check("dut1_load_data", ld1, e.data);
               check("dut1_latency", cyc - e.issue, e.lat);
            end
         end
         if (dreq1) begin
            n_chk++; n_err++;
            $display("FAIL dut1_bus_req: got data_req_o=1, expected 0");
         end
      end
   end

   task automatic beat(input logic [31:0] a, input logic we, input logic [3:0] be,
                       input logic [31:0] wd, input bit chk_wd, input int stall,
                       input logic [31:0] rd, input logic er);
      beat_t b;
      b.addr = a; b.we = we; b.be = be; b.wdata = wd; b.chk_wd = chk_wd;
      b.stall = stall; b.rdata = rd; b.err = er;
      beat_q.push_back(b);
   endtask

   // Called at a negedge: that cycle is cycle 0 of the access.
   task automatic issue(input bit sel, input logic st, input logic un, input lsu_width_e w,
                        input logic [31:0] a, input logic [31:0] d, input logic e_err,
                        input bit e_chk, input logic [31:0] e_data, input int lat);
      exp_t x;
      x.err = e_err; x.chk = e_chk; x.data = e_data; x.lat = lat; x.issue = cyc;
      if (sel) exp1_q.push_back(x);
      else     exp0_q.push_back(x);
      store = st; uns = un; width = w; addr = a; sdata = d;
      if (sel) req1 = 1'b1;
      else     req0 = 1'b1;
      @(negedge clk);
      req0 = 1'b0; req1 = 1'b0;
   endtask

   task automatic wait_done(input bit sel);
      int n;
      n = 0;
      while (!(sel ? valid1 : valid0) && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (n >= 40) begin
         n_chk++; n_err++;
         $display("FAIL timeout_dut%0d: got no valid_o in 40 cycles, expected a completion", sel);
      end
   endtask

   initial begin
      rst = 1'b1; req0 = 1'b0; req1 = 1'b0; store = 1'b0; uns = 1'b0;
      width = LSU_WORD; addr = 32'h0; sdata = 32'h0;
      repeat (3) @(negedge clk);
      check("rst_busy", {31'b0, busy0}, 32'd0);
      check("rst_valid", {31'b0, valid0}, 32'd0);
      check("rst_err", {31'b0, err0}, 32'd0);
      check("rst_data_req", {31'b0, dreq0}, 32'd0);
      check("rst_data_we", {31'b0, dwe0}, 32'd0);
      check("rst_data_be", {28'b0, dbe0}, 32'd0);
      check("rst_data_addr", daddr0, 32'd0);
      check("rst_data_wdata", dwd0, 32'd0);
      check("rst_load_data", ld0, 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // Aligned word store.
      beat(32'h0000_0100, 1'b1, 4'b1111, 32'hDEAD_BEEF, 1'b1, 0, 32'h0, 1'b0);
      issue(0, 1'b1, 1'b0, LSU_WORD, 32'h0000_0100, 32'hDEAD_BEEF, 1'b0, 1'b1, 32'h0, 3);
      wait_done(0); @(negedge clk);

      // Byte load signed, then unsigned back-to-back in the valid cycle.
      beat(32'h0000_0200, 1'b0, 4'b1000, 32'h0, 1'b0, 0, 32'h80FF_0000, 1'b0);
      issue(0, 1'b0, 1'b0, LSU_BYTE, 32'h0000_0203, 32'h0, 1'b0, 1'b1, 32'hFFFF_FF80, 3);
      wait_done(0);
      beat(32'h0000_0200, 1'b0, 4'b1000, 32'h0, 1'b0, 0, 32'h80FF_0000, 1'b0);
      issue(0, 1'b0, 1'b1, LSU_BYTE, 32'h0000_0203, 32'h0, 1'b0, 1'b1, 32'h0000_0080, 3);
      wait_done(0); @(negedge clk);

      // Non-crossing unaligned half (unsigned) and signed half at off=2.
      beat(32'h0000_0100, 1'b0, 4'b0110, 32'h0, 1'b0, 0, 32'h00AB_CD00, 1'b0);
      issue(0, 1'b0, 1'b1, LSU_HALF, 32'h0000_0101, 32'h0, 1'b0, 1'b1, 32'h0000_ABCD, 3);
      wait_done(0); @(negedge clk);
      beat(32'h0000_0100, 1'b0, 4'b1100, 32'h0, 1'b0, 0, 32'h8001_0000, 1'b0);
      issue(0, 1'b0, 1'b0, LSU_HALF, 32'h0000_0102, 32'h0, 1'b0, 1'b1, 32'hFFFF_8001, 3);
      wait_done(0); @(negedge clk);

      // Split word load.
      beat(32'h0000_00FC, 1'b0, 4'b1100, 32'h0, 1'b0, 0, 32'hAABB_0000, 1'b0);
      beat(32'h0000_0100, 1'b0, 4'b0011, 32'h0, 1'b0, 0, 32'h0000_CCDD, 1'b0);
      issue(0, 1'b0, 1'b0, LSU_WORD, 32'h0000_00FE, 32'h0, 1'b0, 1'b1, 32'hCCDD_AABB, 5);
      wait_done(0); @(negedge clk);

      // Split half store wrapping past the top of the address space.
      beat(32'hFFFF_FFFC, 1'b1, 4'b1000, 32'h3400_0000, 1'b1, 0, 32'h0, 1'b0);
      beat(32'h0000_0000, 1'b1, 4'b0001, 32'h0000_0012, 1'b1, 0, 32'h0, 1'b0);
      issue(0, 1'b1, 1'b0, LSU_HALF, 32'hFFFF_FFFF, 32'h0000_1234, 1'b0, 1'b1, 32'hCCDD_AABB, 5);
      wait_done(0); @(negedge clk);

      // Split store with beat-1 bus error: no second beat, load data untouched.
      beat(32'h0000_0200, 1'b1, 4'b1100, 32'h3344_0000, 1'b1, 0, 32'h0, 1'b1);
      issue(0, 1'b1, 1'b0, LSU_WORD, 32'h0000_0202, 32'h1122_3344, 1'b1, 1'b1, 32'hCCDD_AABB, 3);
      wait_done(0); @(negedge clk);

      // Three grant wait states, request fields checked each stalled cycle.
      beat(32'h0000_0300, 1'b0, 4'b1111, 32'h0, 1'b0, 3, 32'h5555_AAAA, 1'b0);
      issue(0, 1'b0, 1'b0, LSU_WORD, 32'h0000_0300, 32'h0, 1'b0, 1'b1, 32'h5555_AAAA, 6);
      wait_done(0); @(negedge clk);

      // Load with bus error keeps the previous result.
      beat(32'h0000_0400, 1'b0, 4'b1111, 32'h0, 1'b0, 0, 32'h9999_9999, 1'b1);
      issue(0, 1'b0, 1'b0, LSU_WORD, 32'h0000_0400, 32'h0, 1'b1, 1'b1, 32'h5555_AAAA, 3);
      wait_done(0); @(negedge clk);

      // Split disabled: crossing accesses fail in two cycles without bus traffic.
      issue(1, 1'b0, 1'b0, LSU_WORD, 32'h0000_0101, 32'h0, 1'b1, 1'b1, 32'h0, 2);
      wait_done(1); @(negedge clk);
      issue(1, 1'b1, 1'b0, LSU_HALF, 32'h0000_0103, 32'hABCD, 1'b1, 1'b1, 32'h0, 2);
      wait_done(1); @(negedge clk);

      // Reset while waiting for the response: back to IDLE, no completion.
      beat(32'h0000_0500, 1'b0, 4'b1111, 32'h0, 1'b0, 0, 32'h1234_5678, 1'b0);
      store = 1'b0; uns = 1'b0; width = LSU_WORD; addr = 32'h0000_0500; req0 = 1'b1;
      @(negedge clk);
      req0 = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("rst_mid_busy", {31'b0, busy0}, 32'd0);
      check("rst_mid_valid", {31'b0, valid0}, 32'd0);
      repeat (4) @(negedge clk);
      check("rst_mid_load_data", ld0, 32'd0);

      check("beats_left", beat_q.size(), 32'd0);
      check("dut0_pending", exp0_q.size(), 32'd0);
      check("dut1_pending", exp1_q.size(), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
